data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
// - Responder end of the processor's load/store interface: a word-organised data RAM behind a valid/ready request/response handshake.
// - Accepts one request at a time, waits LATENCY cycles, then returns load data (RISC-V size/sign rules from funct3) or a store acknowledge.
// - Lets the datapath move from an ideal single-cycle memory to a realistic multi-cycle responder without changing its load/store encoding.
// PARAMETERS
// - DEPTH    64  number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH-1
// - LATENCY  2   cycles from request accept to rsp_valid; legal range 1..15
// PORTS
// - clk         in   1   rising-edge clock; the only clock in the block
// - reset       in   1   asynchronous, active-low reset (asserted when 0)
// - req_valid   in   1   request present
// - req_ready   out  1   responder can accept a request
// - req_write   in   1   1 = store, 0 = load
// - req_addr    in   32  byte address
// - req_funct3  in   3   RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
// - req_wdata   in   32  store data; the low byte/half/word is used according to size
// - rsp_valid   out  1   response present
// - rsp_ready   in   1   requester accepts the response
// - rsp_rdata   out  32  load result after extension; 0 for stores and errors
// - rsp_err     out  1   request rejected; no memory access was made
// BEHAVIOUR
// - Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE. RAM contents are not reset.
// - FSM states: IDLE, BUSY, RESP.
//   - IDLE: req_ready=1. On req_valid, capture all req_* fields, load the counter with LATENCY-1, then go to BUSY.
//   - BUSY: req_ready=0. Decrement the counter each cycle. When the counter is 0, perform the access, register rsp_*, then go to RESP.
//   - RESP: rsp_valid=1. rsp_rdata and rsp_err hold stable until rsp_ready=1, then go to IDLE.
//     No new request is accepted on the cycle the response is consumed.
// - Latency: with the request accepted at edge k, rsp_valid rises after edge k+LATENCY.
// - Loads, using byte lane addr[1:0]:
//   - B: sign-extend the byte. BU: zero-extend the byte.
//   - H: sign-extend the half at addr[1]. HU: zero-extend the half.
//   - W: the whole word.
// - Stores merge into the addressed word; untouched lanes keep their value.
//   - SB writes byte lane addr[1:0].
//   - SH writes half lane addr[1].
//   - SW writes all 4 bytes.
// - The RAM write occurs only on the final BUSY cycle and never in IDLE or RESP.
// - Errors (rsp_err=1, rdata=0, RAM unchanged):
//   - word index addr[31:2] >= DEPTH;
//   - illegal funct3 (011, 110, 111);
//   - store with funct3 BU or HU.
// - Reset asserted mid-BUSY: the pending access is dropped; a store is not committed unless its final BUSY edge has already passed.
// - Reset asserted in RESP: the response is discarded.
// CONFIGURATION
// - Macro MISALIGN_CHECK_EN.
// - Defined: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0, returns rsp_err=1 and makes no access.
// - Undefined: low address bits are ignored as needed. H uses half lane addr[1] (addr[0] ignored); W ignores addr[1:0]. No misalignment error is raised.
// STRUCTURE
// - Package dmem_pkg holds:
//   - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
//   - the state encoding IDLE/BUSY/RESP;
//   - the counter width constant.
// - Sub-module dmem_lane_align (combinational) does load lane select with sign/zero extension and store byte-merge/write-mask generation.
// - The top level holds the FSM, the capture registers, the latency counter and the RAM array.
// TESTING
// - SW 0x10 with 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err=0; rsp_valid exactly LATENCY cycles after accept.
// - Then LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
// - SH 0x12 with 0x00001234, then LW 0x10 -> 0x1234BEEF.
//   SB 0x10 with 0x77, then LW 0x10 -> 0x1234BE77.
// - Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stay stable and req_ready=0; a request presented during this time is not accepted.
// - With DEPTH=64, SW 0x100 -> err=1, and a later LW of every word shows no change.
//   funct3=011 -> err=1.
// - LW 0x11:
//   - with MISALIGN_CHECK_EN defined -> err=1;
//   - undefined -> word at 0x10 is returned.
// - Issue SW 0x20 with 0xCAFEF00D, assert reset in BUSY before the final cycle, release reset -> outputs at reset values; LW 0x20 returns its prior contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder: funct3 codes,
// FSM state encoding, latency counter width and funct3 legality helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wide enough for LATENCY-1 with LATENCY up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Loads accept B/H/W/BU/HU; stores only B/H/W.
    function automatic logic f3_legal(input logic [2:0] funct3, input logic is_write);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_write;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data memory responder.
// Load path: selects byte/half/word from the addressed RAM word and applies
// sign or zero extension. Store path: replicates the store data into its lane
// and merges it with the old word under a byte write mask.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] word_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o,
    output logic [3:0]  wmask_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] lanes;

    // Load lane select and extension; halves ignore addr[0], words ignore addr[1:0].
    always_comb begin
        shifted  = word_i >> {addr_lo_i, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_o = {24'h000000, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_o = {16'h0000, half_sel};
            default: load_data_o = word_i;
        endcase
    end

    // Store lane replication, byte mask and merge with the current word.
    always_comb begin
        case (funct3_i)
            F3_B, F3_BU: begin
                lanes   = {4{wdata_i[7:0]}};
                wmask_o = 4'b0001 << addr_lo_i;
            end
            F3_H, F3_HU: begin
                lanes   = {2{wdata_i[15:0]}};
                wmask_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lanes   = wdata_i;
                wmask_o = 4'b1111;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            store_word_o[8*i +: 8] = wmask_o[i] ? lanes[8*i +: 8] : word_i[8*i +: 8];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: word-organised RAM behind a valid/ready request and
// response handshake with a fixed access latency.
// Optional macro MISALIGN_CHECK_EN: when defined, misaligned halfword/word
// accesses are rejected with rsp_err_o instead of ignoring low address bits.
//
// state | meaning
// IDLE  | ready for a request; captures it on req_valid_i
// BUSY  | latency countdown; access performed when the counter reaches 0
// RESP  | response held stable until rsp_ready_i
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int IDX_W = $clog2(DEPTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [31:0]        addr_q, addr_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [31:0]        mem_q [DEPTH];
    logic [IDX_W-1:0]   word_idx;
    logic [31:0]        mem_word;
    logic [31:0]        load_data;
    logic [31:0]        store_word;
    logic [3:0]         wmask;
    logic               misalign;
    logic               access_err;
    logic               fire;
    logic               mem_we;

    assign word_idx = addr_q[IDX_W+1:2];
    assign mem_word = mem_q[word_idx];
    assign fire     = (state_q == BUSY) && (cnt_q == '0);

`ifdef MISALIGN_CHECK_EN
    assign misalign = (((funct3_q == F3_H) || (funct3_q == F3_HU)) && addr_q[0]) ||
                      ((funct3_q == F3_W) && (addr_q[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign access_err = (addr_q[31:2] >= 30'(DEPTH)) ||
                        !f3_legal(funct3_q, write_q) ||
                        misalign;

    // The only RAM write: final BUSY cycle of an error-free store.
    assign mem_we = fire && write_q && !access_err;

    dmem_lane_align u_align (
        .addr_lo_i    (addr_q[1:0]),
        .funct3_i     (funct3_q),
        .wdata_i      (wdata_q),
        .word_i       (mem_word),
        .load_data_o  (load_data),
        .store_word_o (store_word),
        .wmask_o      (wmask)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = BUSY;
            BUSY:    if (cnt_q == '0) state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        req_ready_o = (state_q == IDLE);
        rsp_valid_o = (state_q == RESP);
    end

    // Request capture, latency countdown and response formation.
    always_comb begin
        cnt_d    = cnt_q;
        write_d  = write_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if ((state_q == IDLE) && req_valid_i) begin
            cnt_d    = CNT_W'(LATENCY - 1);
            write_d  = req_write_i;
            addr_d   = req_addr_i;
            funct3_d = req_funct3_i;
            wdata_d  = req_wdata_i;
        end else if (state_q == BUSY) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                err_d   = access_err;
                rdata_d = (access_err || write_q) ? 32'h0 : load_data;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // RAM array; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[word_idx] <= store_word;
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a byte-array reference model.
module tb_data_mem_responder;

    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] mb [4*DEPTH];

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_funct3_i (req_funct3),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: little-endian byte memory with RISC-V load/store rules.
    task automatic model_access(input logic w, input logic [31:0] a, input logic [2:0] f,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int b;
        logic [15:0] h;
        er = (a / 4 >= DEPTH) || (f == 3) || (f == 6) || (f == 7) || (w && (f == 4 || f == 5));
`ifdef MISALIGN_CHECK_EN
        if (((f == 1 || f == 5) && a[0]) || (f == 2 && a[1:0] != 0)) er = 1'b1;
`endif
        rd = 32'h0;
        if (er) return;
        if (w) begin
            case (f)
                0: mb[a] = wd[7:0];
                1: begin b = int'(a) & ~1; mb[b] = wd[7:0]; mb[b+1] = wd[15:8]; end
                default: begin
                    b = int'(a) & ~3;
                    for (int i = 0; i < 4; i++) mb[b+i] = wd[8*i +: 8];
                end
            endcase
        end else begin
            case (f)
                0: rd = 32'($signed(mb[a]));
                4: rd = {24'h0, mb[a]};
                1, 5: begin
                    b = int'(a) & ~1;
                    h = {mb[b+1], mb[b]};
                    rd = (f == 1) ? 32'($signed(h)) : {16'h0, h};
                end
                default: begin
                    b = int'(a) & ~3;
                    rd = {mb[b+3], mb[b+2], mb[b+1], mb[b]};
                end
            endcase
        end
    endtask

    // Drives one request with rsp_ready high; returns response and edges from accept to rsp_valid.
    task automatic xact(input logic w, input logic [31:0] a, input logic [2:0] f, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_funct3 = f; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) lat = -1;
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_fill();
        logic [31:0] rd, erd, wd;
        logic er, eer;
        int lat;
        for (int i = 0; i < DEPTH; i++) begin
            wd = $urandom;
            model_access(1'b1, 32'(4*i), 3'b010, wd, erd, eer);
            xact(1'b1, 32'(4*i), 3'b010, wd, rd, er, lat);
            checks++;
            if (rd !== erd || er !== eer || lat != LATENCY) begin
                errors++;
                $display("FAIL fill_sw[%0d]: got rdata=%h err=%b lat=%0d, want %h %b %0d",
                         i, rd, er, lat, erd, eer, LATENCY);
            end
        end
    endtask

    typedef struct { logic w; logic [31:0] a; logic [2:0] f; logic [31:0] wd; logic [31:0] exp; logic ee; } dir_t;

    task automatic test_directed();
        dir_t tbl[10];
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat;
        tbl[0] = '{1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1] = '{1'b0, 32'h10, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b0, 32'h13, 3'b000, 32'h0,        32'hFFFFFFDE, 1'b0};
        tbl[3] = '{1'b0, 32'h13, 3'b100, 32'h0,        32'h000000DE, 1'b0};
        tbl[4] = '{1'b0, 32'h10, 3'b001, 32'h0,        32'hFFFFBEEF, 1'b0};
        tbl[5] = '{1'b0, 32'h12, 3'b101, 32'h0,        32'h0000DEAD, 1'b0};
        tbl[6] = '{1'b1, 32'h12, 3'b001, 32'h00001234, 32'h0,        1'b0};
        tbl[7] = '{1'b0, 32'h10, 3'b010, 32'h0,        32'h1234BEEF, 1'b0};
        tbl[8] = '{1'b1, 32'h10, 3'b000, 32'h00000077, 32'h0,        1'b0};
        tbl[9] = '{1'b0, 32'h10, 3'b010, 32'h0,        32'h1234BE77, 1'b0};
        for (int i = 0; i < 10; i++) begin
            model_access(tbl[i].w, tbl[i].a, tbl[i].f, tbl[i].wd, mrd, mer);
            xact(tbl[i].w, tbl[i].a, tbl[i].f, tbl[i].wd, rd, er, lat);
            checks++;
            if (rd !== tbl[i].exp || er !== tbl[i].ee || lat != LATENCY) begin
                errors++;
                $display("FAIL directed[%0d]: got rdata=%h err=%b lat=%0d, want %h %b %0d",
                         i, rd, er, lat, tbl[i].exp, tbl[i].ee, LATENCY);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r0, erd;
        logic e0, eer;
        int n;
        model_access(1'b0, 32'h10, 3'b010, 32'h0, erd, eer);
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        r0 = rsp_rdata; e0 = rsp_err;
        checks++;
        if (!rsp_valid || r0 !== erd || e0 !== eer) begin
            errors++;
            $display("FAIL bp_first: got valid=%b rdata=%h err=%b, want 1 %h %b", rsp_valid, r0, e0, erd, eer);
        end
        // A store offered while the response is stalled must be ignored.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_funct3 = 3'b010; req_wdata = 32'h55555555;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== r0 || rsp_err !== e0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h err=%b ready=%b, want 1 %h %b 0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready, r0, e0);
            end
        end
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        xact(1'b1, 32'h100, 3'b010, 32'hA5A5A5A5, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_range: got err=%b rdata=%h, want 1 0", er, rd);
        end
        xact(1'b0, 32'h10, 3'b011, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_f3_011: got err=%b rdata=%h, want 1 0", er, rd);
        end
        xact(1'b1, 32'h14, 3'b100, 32'h12345678, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_store_bu: got err=%b rdata=%h, want 1 0", er, rd);
        end
        // Nothing above (nor the ignored stalled store) may have changed the RAM.
        for (int i = 0; i < DEPTH; i++) begin
            model_access(1'b0, 32'(4*i), 3'b010, 32'h0, erd, eer);
            xact(1'b0, 32'(4*i), 3'b010, 32'h0, rd, er, lat);
            checks++;
            if (rd !== erd || er !== eer) begin
                errors++;
                $display("FAIL sweep[%0d]: got rdata=%h err=%b, want %h %b", i, rd, er, erd, eer);
            end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        model_access(1'b0, 32'h11, 3'b010, 32'h0, erd, eer);
`ifdef MISALIGN_CHECK_EN
        eer = 1'b1; erd = 32'h0;
`else
        eer = 1'b0; erd = 32'h1234BE77;
`endif
        xact(1'b0, 32'h11, 3'b010, 32'h0, rd, er, lat);
        checks++;
        if (rd !== erd || er !== eer) begin
            errors++;
            $display("FAIL misalign_lw: got rdata=%h err=%b, want %h %b", rd, er, erd, eer);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, wd;
        logic er, eer, w;
        logic [2:0] f;
        int lat;
        for (int i = 0; i < 300; i++) begin
            w  = 1'($urandom_range(0, 1));
            f  = 3'($urandom_range(0, 7));
            wd = $urandom;
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = 32'($urandom_range(256, 300));
                default: a = 32'($urandom_range(0, 255));
            endcase
            model_access(w, a, f, wd, erd, eer);
            xact(w, a, f, wd, rd, er, lat);
            checks++;
            if (rd !== erd || er !== eer || lat != LATENCY) begin
                errors++;
                $display("FAIL random[%0d] w=%b a=%h f=%0d: got rdata=%h err=%b lat=%0d, want %h %b %0d",
                         i, w, a, f, rd, er, lat, erd, eer, LATENCY);
            end
        end
    endtask

    task automatic test_reset_busy();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_outputs: got ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_access(1'b0, 32'h20, 3'b010, 32'h0, erd, eer);
        xact(1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat);
        checks++;
        if (rd !== erd || er !== eer) begin
            errors++;
            $display("FAIL rst_busy_dropped: got rdata=%h err=%b, want %h %b", rd, er, erd, eer);
        end
    endtask

    task automatic test_reset_resp();
        int n;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8; req_funct3 = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_resp: got valid=%b ready=%b rdata=%h, want 0 1 0", rsp_valid, req_ready, rsp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_funct3 = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_fill();
        test_directed();
        test_backpressure();
        test_errors();
        test_misalign();
        test_random();
        test_reset_busy();
        test_reset_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
